// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array result path.
// Holds the drain FSM state encoding and the row/column index width rule.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CAPTURE,
    STREAM,
    DONE
  } drain_state_t;

  // A 1x1 array still needs a one-bit index so port widths never collapse to zero.
  function automatic int idx_w(input int size);
    return (size <= 1) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/drain_index_counter.sv
// Row-major 2-D index walker for the result drain.
// Steps the column on each advance, carries into the row, and flags the final element.
module drain_index_counter
  import systolic_pkg::*;
#(
  parameter int SIZE = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    advance,
  output logic [idx_w(SIZE)-1:0]  row,
  output logic [idx_w(SIZE)-1:0]  col,
  output logic                    wrap
);

  localparam int IW = idx_w(SIZE);
  localparam logic [IW-1:0] MAX_IDX = IW'(SIZE - 1);

  logic col_end;
  logic row_end;

  assign col_end = (col == MAX_IDX);
  assign row_end = (row == MAX_IDX);
  assign wrap    = advance && col_end && row_end;

  // Wrapping back to (0,0) after the last element leaves the counter ready for the next matrix.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Waits out the array compute latency, snapshots the N x N result grid,
// then streams it row-major over a valid/ready interface.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int SIZE           = 3,
  parameter int COMPUTE_CYCLES = 3 * SIZE + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WIDTH-1:0]        result [SIZE-1:0][SIZE-1:0],
  output logic [WIDTH-1:0]        out_data,
  output logic [idx_w(SIZE)-1:0]  out_row,
  output logic [idx_w(SIZE)-1:0]  out_col,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int IW = idx_w(SIZE);
  localparam int CW = (COMPUTE_CYCLES < 2) ? 1 : $clog2(COMPUTE_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(COMPUTE_CYCLES - 1);

  drain_state_t state;
  drain_state_t state_next;

  logic [CW-1:0]    wait_cnt;
  logic             cnt_load;
  logic             cnt_dec;
  logic             capture;
  logic             handshake;
  logic             last_wrap;
  logic [WIDTH-1:0] snapshot [SIZE-1:0][SIZE-1:0];

  assign handshake = out_valid && out_ready;

  drain_index_counter #(
    .SIZE (SIZE)
  ) u_index (
    .clock   (clock),
    .reset   (reset),
    .clear   (capture),
    .advance (handshake),
    .row     (out_row),
    .col     (out_col),
    .wrap    (last_wrap)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    capture    = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          cnt_load   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          state_next = CAPTURE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      CAPTURE: begin
        capture    = 1'b1;
        state_next = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        if (last_wrap) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (cnt_load) begin
      wait_cnt <= WAIT_LOAD;
    end else if (cnt_dec) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // The grid is only sampled in CAPTURE, so array activity during STREAM cannot leak out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          snapshot[r][c] <= '0;
        end
      end
    end else if (capture) begin
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          snapshot[r][c] <= result[r][c];
        end
      end
    end
  end

  assign out_data = out_valid ? snapshot[out_row][out_col] : '0;
  assign out_last = out_valid && (out_row == IW'(SIZE - 1)) && (out_col == IW'(SIZE - 1));

endmodule

// File: tb/tb_systolic_result_drain.sv
// Scoreboard bench for systolic_result_drain: expected beats are queued from a
// matrix-product model at start and popped as the drain hands them off.
module tb_systolic_result_drain;

  localparam int WIDTH   = 16;
  localparam int SIZE    = 3;
  localparam int COMPUTE = 3 * SIZE + 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       row;
    logic [1:0]       col;
    logic             last;
  } beat_t;

  logic             clock;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] result [SIZE-1:0][SIZE-1:0];
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_row;
  logic [1:0]       out_col;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             done;

  int    assert_count;
  int    fail_count;
  int    mat_a [SIZE][SIZE];
  int    mat_b [SIZE][SIZE];
  beat_t exp_q [$];

  systolic_result_drain #(
    .WIDTH          (WIDTH),
    .SIZE           (SIZE),
    .COMPUTE_CYCLES (COMPUTE)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .result    (result),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    assert_count++;
    if (got !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, expected);
    end
  endtask

  // Row-major product, truncated to the element width as the array would.
  function automatic logic [WIDTH-1:0] product(input int r, input int c);
    int acc;
    acc = 0;
    for (int k = 0; k < SIZE; k++) acc += mat_a[r][k] * mat_b[k][c];
    return WIDTH'(acc);
  endfunction

  task automatic setIdentityA();
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        mat_a[r][c] = (r == c) ? 1 : 0;
  endtask

  task automatic setSequenceB();
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        mat_b[r][c] = r * SIZE + c + 1;
  endtask

  task automatic compareBeat(input beat_t got, input beat_t want, input string pfx);
    checkOutput({pfx, "_data"}, 32'(got.data), 32'(want.data));
    checkOutput({pfx, "_row"},  32'(got.row),  32'(want.row));
    checkOutput({pfx, "_col"},  32'(got.col),  32'(want.col));
    checkOutput({pfx, "_last"}, 32'(got.last), 32'(want.last));
  endtask

  // ready_mode 0 holds ready high, 1 drives the 1,0,0 pattern; start pulses at
  // wait_start_cyc and stream_start_ofs cycles after first valid (negative = none).
  task automatic applyStimulus(input int ready_mode, input int wait_start_cyc,
                               input int stream_start_ofs, input bit corrupt,
                               input int reset_after);
    int    cyc, hs, dones, first_valid, last_hs, pat, idle_valid, idle_done;
    bit    prev_stall, finished;
    beat_t held, want, now;

    @(negedge clock);
    exp_q.delete();
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        result[r][c] = product(r, c);
        want.data = product(r, c);
        want.row  = 2'(r);
        want.col  = 2'(c);
        want.last = (r == SIZE - 1) && (c == SIZE - 1);
        exp_q.push_back(want);
      end
    end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1; hs = 0; dones = 0; first_valid = -1; last_hs = -1; pat = 0;
    prev_stall = 1'b0; finished = 1'b0;

    while (!finished && cyc < 300) begin
      start = (cyc == wait_start_cyc) ||
              (first_valid >= 0 && stream_start_ofs >= 0 && cyc == first_valid + stream_start_ofs);
      out_ready = (ready_mode == 0) ? 1'b1 : (pat % 3 == 0);
      now = {out_data, out_row, out_col, out_last};
      if (prev_stall) begin
        compareBeat(now, held, "stall_hold");
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
      end
      if (out_valid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          checkOutput("first_valid_cycle", cyc, COMPUTE + 2);
          if (corrupt) begin
            for (int r = 0; r < SIZE; r++)
              for (int c = 0; c < SIZE; c++)
                result[r][c] = 16'hFFFF;
          end
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat", 32'd1, 32'd0);
          end else begin
            want = exp_q.pop_front();
            compareBeat(now, want, "beat");
          end
          hs++;
          last_hs = cyc;
          prev_stall = 1'b0;
          if (hs == reset_after) begin
            start = 1'b0;
            @(posedge clock);
            #1 reset = 1'b1;
            #1;
            checkOutput("reset_valid", 32'(out_valid), 32'd0);
            checkOutput("reset_busy",  32'(busy),      32'd0);
            checkOutput("reset_done",  32'(done),      32'd0);
            checkOutput("reset_data",  32'(out_data),  32'd0);
            exp_q.delete();
            @(negedge clock);
            reset = 1'b0;
            return;
          end
        end else begin
          prev_stall = 1'b1;
          held = now;
        end
        pat++;
      end else begin
        prev_stall = 1'b0;
      end
      if (done) begin
        dones++;
        checkOutput("done_after_last_hs", cyc, last_hs + 1);
        checkOutput("queue_empty_at_done", exp_q.size(), 0);
      end else if (dones > 0) begin
        checkOutput("busy_after_done", 32'(busy), 32'd0);
        finished = 1'b1;
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (!finished) begin
      checkOutput("drain_timeout", 32'd1, 32'd0);
    end else begin
      idle_valid = 0;
      idle_done  = 0;
      for (int i = 0; i < 2 * COMPUTE; i++) begin
        if (out_valid) idle_valid++;
        if (done) idle_done++;
        @(negedge clock);
      end
      checkOutput("idle_no_valid", idle_valid, 0);
      checkOutput("idle_no_done", idle_done, 0);
    end
    checkOutput("done_count", dones, 1);
  endtask

  initial begin
    assert_count = 0;
    fail_count   = 0;
    reset        = 1'b1;
    start        = 1'b0;
    out_ready    = 1'b0;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        result[r][c] = '0;
    repeat (2) @(negedge clock);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy_init", 32'(busy),      32'd0);
    checkOutput("reset_done_init", 32'(done),      32'd0);
    checkOutput("reset_out_data",  32'(out_data),  32'd0);
    checkOutput("reset_out_last",  32'(out_last),  32'd0);
    reset = 1'b0;

    $display("[TB] identity pass-through");
    setIdentityA();
    setSequenceB();
    applyStimulus(0, -1, -1, 1'b0, -1);

    $display("[TB] backpressure");
    applyStimulus(1, -1, -1, 1'b0, -1);

    $display("[TB] start while busy");
    applyStimulus(0, 3, 2, 1'b0, -1);
    applyStimulus(1, 5, 4, 1'b0, -1);

    $display("[TB] reset mid-stream then fresh run");
    applyStimulus(0, -1, -1, 1'b0, 4);
    applyStimulus(0, -1, -1, 1'b0, -1);

    $display("[TB] capture isolation");
    mat_a[0][0] = 2; mat_a[0][1] = 0; mat_a[0][2] = 1;
    mat_a[1][0] = 0; mat_a[1][1] = 1; mat_a[1][2] = 0;
    mat_a[2][0] = 1; mat_a[2][1] = 1; mat_a[2][2] = 1;
    applyStimulus(1, -1, -1, 1'b1, -1);

    $display("[TB] full-scale values");
    setIdentityA();
    for (int r = 0; r < SIZE; r++) begin
      mat_b[r][0] = 16'hFFFF;
      mat_b[r][1] = 16'h8000;
      mat_b[r][2] = 16'h0001;
    end
    applyStimulus(0, -1, -1, 1'b0, -1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
